// File: rtl/paddle_pkg.sv
// paddle_pkg: shared types and default geometry for the Pong paddle
// controller. The POS_* defaults are also used by the collision logic and
// the VGA renderer, so they live here rather than in the paddle module.
//   state_e : paddle FSM state (IDLE / UP / DN), 2 bits
//   req_e   : direction request derived from buttons or auto tracking
//   manual_req() : button pair -> request (both pressed cancels)
package paddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DN   = 2'd2
  } req_e;

  localparam int POS_W_DEF    = 10;
  localparam int POS_MIN_DEF  = 10;
  localparam int POS_MAX_DEF  = 470;
  localparam int POS_INIT_DEF = 60;

  // Exactly one button held gives a direction; both or neither is no request.
  function automatic req_e manual_req(input logic up, input logic dn);
    if (up && !dn) return REQ_UP;
    if (dn && !up) return REQ_DN;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/paddle_ctrl_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle enable every DIV
// clocks, in the clk domain (no derived clock). Shared with ball_ctrl.
//   clk  : system clock
//   rst  : synchronous active-high reset; counter cleared, tick suppressed
//   tick : high for one cycle when the counter sits at DIV-1
module tick_gen #(
  parameter int DIV = 131072
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Gated with rst so a held reset never produces a tick.
  assign tick = (cnt_q == LAST) && !rst;

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: Pong paddle position controller.
// Buttons (2-flop synchronised) or an auto-tracking target produce a
// direction request; on each movement tick the FSM moves the paddle by a
// step that grows while the same direction is held, clamped to
// [POS_MIN, POS_MAX]. UP decreases pos, DN increases it.
//   clk, rst       : clock, synchronous active-high reset
//   btn_up, btn_dn : raw async button levels
//   auto_mode      : 1 = track target_y, buttons ignored
//   freeze         : 1 = hold position (ticks keep counting)
//   target_y       : auto-mode target
//   pos            : registered paddle position
//   moving         : registered, 1 while FSM is not IDLE
//   at_min, at_max : registered limit flags
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int POS_MIN     = POS_MIN_DEF,
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int POS_INIT    = POS_INIT_DEF,
  parameter int TICK_DIV    = 131072,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 16,
  parameter int DEADBAND    = 4,
  parameter int STEP_AUTO   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             auto_mode,
  input  logic             freeze,
  input  logic [POS_W-1:0] target_y,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             at_min,
  output logic             at_max
);

  // One extra bit so pos+step and target+deadband never wrap.
  localparam int AW   = POS_W + 1;
  localparam int CNTW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [AW-1:0]    MIN_W    = AW'(POS_MIN);
  localparam logic [AW-1:0]    MAX_W    = AW'(POS_MAX);
  localparam logic [AW-1:0]    DB_W     = AW'(DEADBAND);
  localparam logic [POS_W-1:0] S_MIN    = POS_W'(STEP_MIN);
  localparam logic [POS_W-1:0] S_MAX    = POS_W'(STEP_MAX);
  localparam logic [POS_W-1:0] S_AUTO   = POS_W'(STEP_AUTO);
  localparam logic [CNTW-1:0]  ACC_LAST = CNTW'(ACCEL_TICKS - 1);

  logic [1:0]       up_sync_q, dn_sync_q;
  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] step_q, step_d, mv_step;
  logic [CNTW-1:0]  acc_q, acc_d;
  logic             moving_q, at_min_q, at_max_q;
  logic             at_min_d, at_max_d;
  logic             tick;
  req_e             req;
  logic [AW-1:0]    pos_w, tgt_w, step_w, nxt_w;
  logic             do_move, mv_up, same_dir;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Button synchronisers; only bit [1] is ever consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[0], btn_up};
      dn_sync_q <= {dn_sync_q[0], btn_dn};
    end
  end

  // Direction request. Auto mode compares against pos with a deadband so
  // the paddle settles instead of dithering around the target.
  always_comb begin
    req   = REQ_NONE;
    pos_w = {1'b0, pos_q};
    tgt_w = {1'b0, target_y};
    if (auto_mode) begin
      if (tgt_w + DB_W < pos_w)      req = REQ_UP;
      else if (tgt_w > pos_w + DB_W) req = REQ_DN;
    end else begin
      req = manual_req(up_sync_q[1], dn_sync_q[1]);
    end
  end

  assign same_dir = ((req == REQ_UP) && (state_q == ST_UP)) ||
                    ((req == REQ_DN) && (state_q == ST_DN));

  // FSM next state, step and accel bookkeeping; evaluated on ticks only.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    do_move = 1'b0;
    mv_up   = 1'b0;
    mv_step = S_MIN;
    if (tick) begin
      if (freeze || (req == REQ_NONE)) begin
        state_d = ST_IDLE;
        step_d  = S_MIN;
        acc_d   = '0;
      end else begin
        do_move = 1'b1;
        mv_up   = (req == REQ_UP);
        state_d = mv_up ? ST_UP : ST_DN;
        if (auto_mode) begin
          // Fixed speed in auto; accel state kept parked at its start.
          step_d  = S_MIN;
          acc_d   = '0;
          mv_step = S_AUTO;
        end else if (same_dir) begin
          // The move on the tick that completes an accel period already
          // uses the raised step, so each step size is used ACCEL_TICKS
          // times counting the entry move.
          if (acc_q == ACC_LAST) begin
            acc_d  = '0;
            step_d = (step_q >= S_MAX) ? S_MAX : step_q + POS_W'(1);
          end else begin
            acc_d = acc_q + CNTW'(1);
          end
          mv_step = step_d;
        end else begin
          // Entry from IDLE or reversal: restart at the minimum step.
          step_d  = S_MIN;
          acc_d   = '0;
          mv_step = S_MIN;
        end
      end
    end
  end

  // Saturating move. The UP bound is checked before subtracting so the
  // result never wraps below zero.
  always_comb begin
    step_w = {1'b0, mv_step};
    nxt_w  = pos_w;
    if (do_move) begin
      if (mv_up) nxt_w = (pos_w >= step_w + MIN_W) ? pos_w - step_w : MIN_W;
      else       nxt_w = (pos_w + step_w > MAX_W)  ? MAX_W : pos_w + step_w;
    end
    pos_d    = nxt_w[POS_W-1:0];
    at_min_d = (nxt_w == MIN_W);
    at_max_d = (nxt_w == MAX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= POS_W'(POS_INIT);
      step_q   <= S_MIN;
      acc_q    <= '0;
      moving_q <= 1'b0;
      at_min_q <= (POS_INIT == POS_MIN);
      at_max_q <= (POS_INIT == POS_MAX);
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      moving_q <= (state_d != ST_IDLE);
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign pos    = pos_q;
  assign moving = moving_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed button/auto/freeze/reset scenarios, a
// rule-level reference model compared every cycle, and literal position
// checks after each movement tick.
module tb_paddle_ctrl;

  localparam int W = 10, PMIN = 10, PMAX = 470, PINIT = 60, DIV = 4;
  localparam int SMIN = 1, SMAX = 3, ACC = 2, DB = 4, SAUTO = 2;

  logic         clk = 1'b0;
  logic         rst, btn_up, btn_dn, auto_mode, freeze;
  logic [W-1:0] target_y, pos;
  logic         moving, at_min, at_max;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .POS_W(W), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT),
    .TICK_DIV(DIV), .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(ACC),
    .DEADBAND(DB), .STEP_AUTO(SAUTO)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .auto_mode(auto_mode), .freeze(freeze), .target_y(target_y),
    .pos(pos), .moving(moving), .at_min(at_min), .at_max(at_max)
  );

  int vec = 0, err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // dir: -1 = up, 0 = idle, +1 = down. Ticks come from cycles since reset.
  int m_pos, m_dir, m_step, m_cnt, m_n, m_ticks, m_req, m_s;
  bit m_s1u, m_s2u, m_s1d, m_s2d, m_valid, m_tk;

  function automatic int req_of(input bit a, input int tgt, input int p,
                                input bit u, input bit d);
    if (a) begin
      if (tgt + DB < p) return -1;
      if (tgt > p + DB) return 1;
      return 0;
    end
    if (u && !d) return -1;
    if (d && !u) return 1;
    return 0;
  endfunction

  initial begin
    m_valid = 0;
    m_ticks = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pos = PINIT; m_dir = 0; m_step = SMIN; m_cnt = 0; m_n = 0;
        m_s1u = 0; m_s2u = 0; m_s1d = 0; m_s2d = 0;
        m_valid = 1;
      end else begin
        m_tk = ((m_n % DIV) == DIV - 1);
        m_n++;
        if (m_tk) begin
          m_ticks++;
          m_req = req_of(auto_mode, int'(target_y), m_pos, m_s2u, m_s2d);
          if (freeze || m_req == 0) begin
            m_dir = 0; m_step = SMIN; m_cnt = 0;
          end else begin
            if (auto_mode) begin
              m_s = SAUTO; m_step = SMIN; m_cnt = 0;
            end else if (m_req == m_dir) begin
              if (m_cnt == ACC - 1) begin
                m_cnt = 0;
                m_step = (m_step + 1 > SMAX) ? SMAX : m_step + 1;
              end else m_cnt++;
              m_s = m_step;
            end else begin
              m_step = SMIN; m_cnt = 0; m_s = SMIN;
            end
            m_dir = m_req;
            if (m_dir < 0) m_pos = (m_pos - m_s < PMIN) ? PMIN : m_pos - m_s;
            else           m_pos = (m_pos + m_s > PMAX) ? PMAX : m_pos + m_s;
          end
        end
        m_s2u = m_s1u; m_s1u = btn_up;
        m_s2d = m_s1d; m_s1d = btn_dn;
      end
      @(negedge clk);
      if (m_valid) begin
        chk("model_pos", int'(pos), m_pos);
        chk("model_moving", int'(moving), int'(m_dir != 0));
        chk("model_at_min", int'(at_min), int'(m_pos == PMIN));
        chk("model_at_max", int'(at_max), int'(m_pos == PMAX));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns at the negedge following the next movement tick.
  task automatic next_tick();
    int t0 = m_ticks;
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_ticks == t0 && k < 3 * DIV);
    if (m_ticks == t0) chk("tick_timeout", 0, 1);
  endtask

  task automatic run_until_idle(input int maxt);
    for (int i = 0; i < maxt; i++) begin
      next_tick();
      if (!moving) break;
    end
    chk("settle_idle", int'(moving), 0);
  endtask

  int dn_seq[7]  = '{61, 62, 64, 66, 69, 72, 75};
  int up_seq[3]  = '{11, 10, 10};
  int top_seq[7] = '{461, 462, 464, 466, 469, 470, 470};
  int rev_seq[3] = '{469, 468, 466};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; btn_up = 0; btn_dn = 1; auto_mode = 0; freeze = 0; target_y = '0;
    // Reset held with a button pressed: nothing may move.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_pos", int'(pos), 60);
      chk("rst_moving", int'(moving), 0);
      chk("rst_at_min", int'(at_min), 0);
      chk("rst_at_max", int'(at_max), 0);
    end
    btn_dn = 0;
    rst = 0;

    // Hold down: accelerating steps 1,1,2,2,3,3,3.
    next_tick();
    chk("idle_pos", int'(pos), 60);
    btn_dn = 1;
    for (int i = 0; i < 7; i++) begin
      next_tick();
      chk("dn_hold", int'(pos), dn_seq[i]);
      chk("dn_moving", int'(moving), 1);
    end
    // Reverse at step 3: first up move is 1.
    btn_dn = 0; btn_up = 1;
    next_tick(); chk("reverse_up", int'(pos), 74);
    btn_dn = 1; btn_up = 0;
    next_tick(); chk("reverse_dn", int'(pos), 75);
    btn_up = 1;
    next_tick(); chk("both_pos", int'(pos), 75); chk("both_moving", int'(moving), 0);

    // Auto: park at 99, nudge to 100 manually.
    btn_up = 0; btn_dn = 0; auto_mode = 1; target_y = 10'd102;
    run_until_idle(30); chk("auto_to_99", int'(pos), 99);
    auto_mode = 0; btn_dn = 1;
    next_tick(); chk("nudge_100", int'(pos), 100);
    btn_dn = 0;
    next_tick(); chk("nudge_idle", int'(moving), 0);
    auto_mode = 1; target_y = 10'd103;
    next_tick(); next_tick(); chk("deadband_hold", int'(pos), 100);
    target_y = 10'd200;
    next_tick(); chk("auto_dn1", int'(pos), 102);
    next_tick(); chk("auto_dn2", int'(pos), 104);
    next_tick(); chk("auto_dn3", int'(pos), 106);
    target_y = 10'd50;
    next_tick(); chk("auto_rev", int'(pos), 104);
    run_until_idle(40); chk("auto_up_stop", int'(pos), 54);

    // Lower limit: park at 12, then hold up.
    target_y = 10'd8;
    run_until_idle(40); chk("auto_to_12", int'(pos), 12);
    auto_mode = 0; btn_up = 1;
    for (int i = 0; i < 3; i++) begin
      next_tick(); chk("up_limit", int'(pos), up_seq[i]);
    end
    chk("at_min_flag", int'(at_min), 1);
    chk("at_min_moving", int'(moving), 1);
    btn_up = 0;
    next_tick(); chk("up_release", int'(moving), 0);

    // Upper limit: park at 460, then hold down.
    auto_mode = 1; target_y = 10'd464;
    run_until_idle(300); chk("auto_to_460", int'(pos), 460);
    auto_mode = 0; btn_dn = 1;
    for (int i = 0; i < 7; i++) begin
      next_tick(); chk("dn_limit", int'(pos), top_seq[i]);
    end
    chk("at_max_flag", int'(at_max), 1);
    chk("at_max_moving", int'(moving), 1);

    // Freeze during a hold, then resume at the minimum step.
    btn_dn = 0; btn_up = 1;
    for (int i = 0; i < 3; i++) begin
      next_tick(); chk("up_from_max", int'(pos), rev_seq[i]);
    end
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      next_tick(); chk("freeze_pos", int'(pos), 466); chk("freeze_moving", int'(moving), 0);
    end
    freeze = 0;
    next_tick(); chk("unfreeze_step", int'(pos), 465);

    // Reset mid-hold.
    rst = 1;
    @(negedge clk);
    chk("midrst_pos", int'(pos), 60);
    chk("midrst_moving", int'(moving), 0);
    repeat (2) @(negedge clk);
    rst = 0; btn_up = 0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
